// File: rtl/sram_req_arbiter_pkg.sv
// Shared encodings for the sram request arbiter: FSM states, requester ids and
// transfer size codes.
package sram_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_t;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    localparam logic [1:0] ARB_SIZE_BYTE = 2'd0;
    localparam logic [1:0] ARB_SIZE_HALF = 2'd1;
    localparam logic [1:0] ARB_SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_order_fifo.sv
// Order FIFO remembering which requester owns each outstanding transaction,
// oldest at the head. DEPTH must be a power of two so the pointers wrap freely.
module sram_req_arbiter_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] ids;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ids    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = ids[rd_ptr];

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between instruction fetch and data requesters.
// Define ARB_RR_EN for round-robin tie-breaking; default is data-over-inst priority.
module sram_req_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inst_req,
    input  logic             inst_wr,
    input  logic [1:0]       inst_size,
    input  logic [31:0]      inst_addr,
    input  logic [3:0]       inst_wstrb,
    input  logic [31:0]      inst_wdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,
    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [31:0]      data_addr,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       mem_size,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_wdata,
    input  logic             mem_addr_ok,
    input  logic             mem_data_ok,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] inst_io_cnt,
    output logic [CNT_W-1:0] data_io_cnt
);
    import sram_req_arbiter_pkg::*;

    arb_state_t state;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       grant_valid;
    logic       grant_id;
    logic       accept;
    logic       resp;

`ifdef ARB_RR_EN
    logic last_grant;
`endif

    // A locked grant keeps the port on one requester until the downstream accepts it.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ARB_ID_DATA;
        case (state)
            ARB_IDLE: begin
                if (!fifo_full && (inst_req || data_req)) begin
                    grant_valid = 1'b1;
`ifdef ARB_RR_EN
                    if (inst_req && data_req) begin
                        grant_id = (last_grant == ARB_ID_DATA) ? ARB_ID_INST : ARB_ID_DATA;
                    end else begin
                        grant_id = data_req ? ARB_ID_DATA : ARB_ID_INST;
                    end
`else
                    grant_id = data_req ? ARB_ID_DATA : ARB_ID_INST;
`endif
                end
            end
            ARB_LOCK_I: begin
                grant_valid = inst_req;
                grant_id    = ARB_ID_INST;
            end
            ARB_LOCK_D: begin
                grant_valid = data_req;
                grant_id    = ARB_ID_DATA;
            end
            default: ;
        endcase
    end

    assign mem_req   = grant_valid;
    assign mem_wr    = (grant_id == ARB_ID_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (grant_id == ARB_ID_DATA) ? data_size  : inst_size;
    assign mem_addr  = (grant_id == ARB_ID_DATA) ? data_addr  : inst_addr;
    assign mem_wstrb = (grant_id == ARB_ID_DATA) ? data_wstrb : inst_wstrb;
    assign mem_wdata = (grant_id == ARB_ID_DATA) ? data_wdata : inst_wdata;

    assign accept       = mem_req && mem_addr_ok;
    assign resp         = mem_data_ok && !fifo_empty;
    assign inst_addr_ok = accept && (grant_id == ARB_ID_INST);
    assign data_addr_ok = accept && (grant_id == ARB_ID_DATA);
    assign inst_data_ok = resp && (fifo_head == ARB_ID_INST);
    assign data_data_ok = resp && (fifo_head == ARB_ID_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;

    sram_req_arbiter_order_fifo #(
        .DEPTH (DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (grant_id),
        .pop     (resp),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ARB_IDLE;
            inst_io_cnt <= '0;
            data_io_cnt <= '0;
`ifdef ARB_RR_EN
            last_grant  <= ARB_ID_DATA;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_valid && !mem_addr_ok) begin
                        state <= (grant_id == ARB_ID_INST) ? ARB_LOCK_I : ARB_LOCK_D;
                    end
                end
                ARB_LOCK_I, ARB_LOCK_D: begin
                    if (mem_addr_ok) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase

            if (inst_addr_ok && !inst_data_ok) begin
                inst_io_cnt <= inst_io_cnt + 1'b1;
            end else if (!inst_addr_ok && inst_data_ok) begin
                inst_io_cnt <= inst_io_cnt - 1'b1;
            end

            if (data_addr_ok && !data_data_ok) begin
                data_io_cnt <= data_io_cnt + 1'b1;
            end else if (!data_addr_ok && data_data_ok) begin
                data_io_cnt <= data_io_cnt - 1'b1;
            end
`ifdef ARB_RR_EN
            if (accept) begin
                last_grant <= grant_id;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter in its default
// fixed-priority build (ARB_RR_EN undefined).
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [3:0]  inst_io_cnt, data_io_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(
        .DEPTH (4),
        .CNT_W (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wstrb   (inst_wstrb),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .inst_io_cnt  (inst_io_cnt),
        .data_io_cnt  (data_io_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock, then leave a margin before the next edge for driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic dr, input logic aok,
                                 input logic dok, input logic [31:0] rd);
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        inst_wr    = 1'b0;  data_wr    = 1'b1;
        inst_size  = 2'd2;  data_size  = 2'd1;
        inst_wstrb = 4'hF;  data_wstrb = 4'h3;
        inst_wdata = 32'h0; data_wdata = 32'hCAFE_F00D;
        inst_addr  = 32'h0000_1000;
        data_addr  = 32'h0000_2000;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        tick();
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_inst_cnt", {28'd0, inst_io_cnt}, 32'd0);
        checkOutput("rst_data_cnt", {28'd0, data_io_cnt}, 32'd0);
        checkOutput("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        checkOutput("rst_rdata", inst_rdata | data_rdata, 32'd0);
        resetn = 1'b1;

        // Test 1: tie in IDLE goes to data, then inst
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("t1_data_aok", {31'd0, data_addr_ok}, 32'd1);
        checkOutput("t1_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
        checkOutput("t1_mem_addr", mem_addr, 32'h0000_2000);
        checkOutput("t1_mem_wr", {31'd0, mem_wr}, 32'd1);
        checkOutput("t1_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("t1_data_cnt1", {28'd0, data_io_cnt}, 32'd1);
        checkOutput("t1_inst_aok2", {31'd0, inst_addr_ok}, 32'd1);
        checkOutput("t1_mem_addr2", mem_addr, 32'h0000_1000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00A0);
        checkOutput("t1_inst_cnt1", {28'd0, inst_io_cnt}, 32'd1);
        checkOutput("t1_resp0_data", {31'd0, data_data_ok}, 32'd1);
        checkOutput("t1_resp0_rdata", data_rdata, 32'h0000_00A0);
        checkOutput("t1_resp0_irdata", inst_rdata, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00B0);
        checkOutput("t1_resp1_inst", {31'd0, inst_data_ok}, 32'd1);
        checkOutput("t1_resp1_rdata", inst_rdata, 32'h0000_00B0);
        checkOutput("t1_resp1_ddok", {31'd0, data_data_ok}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t1_end_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'd0);

        // Test 2: inst locked while addr_ok stays low, data arrives late
        inst_addr = 32'h0000_3000;
        data_addr = 32'h0000_4000;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_c0_req", {31'd0, mem_req}, 32'd1);
        checkOutput("t2_c0_addr", mem_addr, 32'h0000_3000);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_c1_addr", mem_addr, 32'h0000_3000);
        checkOutput("t2_c1_daok", {31'd0, data_addr_ok}, 32'd0);
        tick();
        checkOutput("t2_c2_addr", mem_addr, 32'h0000_3000);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("t2_c3_iaok", {31'd0, inst_addr_ok}, 32'd1);
        checkOutput("t2_c3_daok", {31'd0, data_addr_ok}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_c4_addr", mem_addr, 32'h0000_4000);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("t2_c5_daok", {31'd0, data_addr_ok}, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077);
        checkOutput("t2_cnts", {24'd0, inst_io_cnt, data_io_cnt}, 32'h0000_0011);
        checkOutput("t2_resp_inst", inst_rdata, 32'h0000_0077);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0088);
        checkOutput("t2_resp_data", data_rdata, 32'h0000_0088);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_end_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'd0);

        // Test 3: I,D,I,D at full rate, responses routed in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2) == 0, (i % 2) == 1, 1'b1, 1'b0, 32'd0);
            checkOutput("t3_aok", {30'd0, inst_addr_ok, data_addr_ok}, ((i % 2) == 0) ? 32'd2 : 32'd1);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t3_cnts", {24'd0, inst_io_cnt, data_io_cnt}, 32'h0000_0022);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h11 * (i + 1));
            if ((i % 2) == 0) begin
                checkOutput("t3_inst_rdata", inst_rdata, 32'h11 * (i + 1));
                checkOutput("t3_inst_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
            end else begin
                checkOutput("t3_data_rdata", data_rdata, 32'h11 * (i + 1));
                checkOutput("t3_data_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
            end
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t3_end_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'd0);

        // Test 4: fill to DEPTH, then overlap accepts with responses
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        checkOutput("t4_full_cnt", {28'd0, data_io_cnt}, 32'd4);
        checkOutput("t4_full_req", {31'd0, mem_req}, 32'd0);
        checkOutput("t4_full_iaok", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        checkOutput("t4_full_req2", {31'd0, mem_req}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0055);
        checkOutput("t4_pop_req", {31'd0, mem_req}, 32'd0);
        checkOutput("t4_pop_data", data_rdata, 32'h0000_0055);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0066);
        checkOutput("t4_ov_iaok", {31'd0, inst_addr_ok}, 32'd1);
        checkOutput("t4_ov_ddok", {31'd0, data_data_ok}, 32'd1);
        checkOutput("t4_ov_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'h0000_0003);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0077);
        checkOutput("t4_same_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'h0000_0012);
        checkOutput("t4_same_ok", {29'd0, data_addr_ok, inst_data_ok, data_data_ok}, 32'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0088);
        checkOutput("t4_same_cnt2", {24'd0, inst_io_cnt, data_io_cnt}, 32'h0000_0012);
        checkOutput("t4_drain0", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0099);
        checkOutput("t4_drain1", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00AA);
        checkOutput("t4_drain2", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        tick();

        // Test 5: stray response with nothing outstanding
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00BB);
        checkOutput("t5_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        checkOutput("t5_rdata", inst_rdata | data_rdata, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t5_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'd0);

        // Test 6: reset with 3 outstanding and inst locked
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("t6_pre_cnt", {28'd0, data_io_cnt}, 32'd3);
        tick();
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        resetn = 1'b1;
        #1;
        checkOutput("t6_cnt", {24'd0, inst_io_cnt, data_io_cnt}, 32'd0);
        checkOutput("t6_mem_req", {31'd0, mem_req}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("t6_idle_addr", mem_addr, 32'h0000_4000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00CC);
        checkOutput("t6_no_resp", {30'd0, inst_data_ok, data_data_ok}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
